// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-register types: EX/MEM control and payload layouts plus
// the occupancy encoding used by the skid stage.
package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic [2:0] mem_write;
  } em_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } em_data_t;

  localparam int EM_CTRL_W = $bits(em_ctrl_t);
  localparam int EM_DATA_W = $bits(em_data_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_count(input occ_e s);
    logic [1:0] n;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream stage, the skid register and the
// downstream stage; master is the surrounding pipeline, slave the register.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EM_CTRL_W,
  parameter int DATA_W = EM_DATA_W
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        count_o;

  modport master (
    output flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, count_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, count_o
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register: FIFO-ordered main/skid entries with a
// ready that depends only on held state, plus flush and occupancy output.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W            = EM_CTRL_W,
  parameter int DATA_W            = EM_DATA_W,
  parameter bit ZERO_CTRL_INVALID = 1'b1
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_skid_if.slave  bus
);

  occ_e              state_r;
  occ_e              state_nxt_s;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;

  logic main_v_s;
  logic skid_v_s;
  logic in_fire_s;
  logic out_fire_s;
  logic load_main_in_s;
  logic load_skid_s;
  logic move_skid_s;

  // Entry-valid flags and handshake fires, all derived from held state
  always_comb begin
    main_v_s   = (state_r != EMPTY);
    skid_v_s   = (state_r == FULL);
    in_fire_s  = bus.in_valid_i & ~skid_v_s;
    out_fire_s = main_v_s & bus.out_ready_i;
  end

  // Next occupancy and which entry registers load this cycle
  always_comb begin
    state_nxt_s    = state_r;
    load_main_in_s = 1'b0;
    load_skid_s    = 1'b0;
    move_skid_s    = 1'b0;
    if (bus.flush_i) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            load_main_in_s = 1'b1;
            state_nxt_s    = ONE;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            load_main_in_s = 1'b1;
            state_nxt_s    = ONE;
          end else if (in_fire_s) begin
            load_skid_s = 1'b1;
            state_nxt_s = FULL;
          end else if (out_fire_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            move_skid_s = 1'b1;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // Occupancy state register; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Entry registers: load only on an accepted input or a skid-to-main move
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl_r <= {CTRL_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
    end else if (bus.flush_i) begin
      // Payload may stay stale; zeroed control keeps side effects out of later stages
      main_ctrl_r <= {CTRL_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
    end else begin
      if (load_main_in_s) begin
        main_ctrl_r <= bus.in_ctrl_i;
        main_data_r <= bus.in_data_i;
      end else if (move_skid_s) begin
        main_ctrl_r <= skid_ctrl_r;
        main_data_r <= skid_data_r;
      end
      if (load_skid_s) begin
        skid_ctrl_r <= bus.in_ctrl_i;
        skid_data_r <= bus.in_data_i;
      end else if (move_skid_s) begin
        skid_ctrl_r <= {CTRL_W{1'b0}};
      end
    end
  end

  // Outputs decoded straight from registers
  always_comb begin
    bus.out_valid_o = main_v_s;
    bus.in_ready_o  = ~skid_v_s;
    bus.count_o     = occ_count(state_r);
    bus.out_data_o  = main_data_r;
    if (ZERO_CTRL_INVALID && !main_v_s) begin
      bus.out_ctrl_o = {CTRL_W{1'b0}};
    end else begin
      bus.out_ctrl_o = main_ctrl_r;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, both
// checked each cycle against a capacity-2 FIFO queue model.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int CW = EM_CTRL_W;
  localparam int DW = EM_DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  int total = 0;
  int bad   = 0;
  logic [CW+DW-1:0] q[$];

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus0 ();

  assign bus.flush_i      = flush;
  assign bus.in_valid_i   = in_valid;
  assign bus.in_ctrl_i    = in_ctrl;
  assign bus.in_data_i    = in_data;
  assign bus.out_ready_i  = out_ready;
  assign bus0.flush_i     = flush;
  assign bus0.in_valid_i  = in_valid;
  assign bus0.in_ctrl_i   = in_ctrl;
  assign bus0.in_data_i   = in_data;
  assign bus0.out_ready_i = out_ready;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ZERO_CTRL_INVALID(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ZERO_CTRL_INVALID(1'b0)) dut_raw (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare outputs with the queue model, then clock once and update the model.
  task automatic step();
    logic [CW+DW-1:0] head;
    logic [CW+DW-1:0] ent;
    bit v, rdy, inf, outf, do_rst, do_flush;
    v    = (q.size() > 0);
    rdy  = (q.size() < 2);
    head = v ? q[0] : {(CW+DW){1'b0}};
    chk_eq("valid", bus.out_valid_o, v);
    chk_eq("ready", bus.in_ready_o, rdy);
    chk_eq("count", bus.count_o, q.size());
    chk_eq("ctrl", bus.out_ctrl_o, v ? head[CW+DW-1:DW] : {CW{1'b0}});
    if (v) chk_eq("data", bus.out_data_o, head[DW-1:0]);
    chk_eq("raw_valid", bus0.out_valid_o, v);
    chk_eq("raw_count", bus0.count_o, q.size());
    if (v) begin
      chk_eq("raw_ctrl", bus0.out_ctrl_o, head[CW+DW-1:DW]);
      chk_eq("raw_data", bus0.out_data_o, head[DW-1:0]);
    end
    inf      = in_valid && rdy;
    outf     = v && out_ready;
    ent      = {in_ctrl, in_data};
    do_rst   = rst;
    do_flush = flush;
    @(posedge clk);
    #1;
    if (do_rst || do_flush) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(ent);
    end
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] rnd;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_ctrl   = 6'h3f;
    in_data   = {{(DW-16){1'b0}}, 16'hdead};
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_valid", bus.out_valid_o, 1'b0);
    chk_eq("rst_ctrl", bus.out_ctrl_o, {CW{1'b0}});
    chk_eq("rst_data", bus.out_data_o, {DW{1'b0}});
    chk_eq("rst_count", bus.count_o, 2'd0);
    chk_eq("rst_ready", bus.in_ready_o, 1'b1);
    chk_eq("rst_raw_ctrl", bus0.out_ctrl_o, {CW{1'b0}});
    q.delete();
    rst      = 1'b0;
    in_valid = 1'b0;

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 6'h25;
      in_data  = DW'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // backpressure fills skid, then drains in order
    out_ready = 1'b0;
    push(6'h25, DW'(32'hA));
    push(6'h25, DW'(32'hB));
    step();
    chk_eq("bp_count", bus.count_o, 2'd2);
    chk_eq("bp_head", bus.out_data_o, DW'(32'hA));
    out_ready = 1'b1;
    repeat (3) step();

    // flush with a simultaneous input that must be dropped
    out_ready = 1'b0;
    push(6'h25, DW'(32'hA));
    push(6'h25, DW'(32'hB));
    flush    = 1'b1;
    push(6'h25, DW'(32'hC));
    flush     = 1'b0;
    chk_eq("fl_ctrl", bus.out_ctrl_o, {CW{1'b0}});
    out_ready = 1'b1;
    repeat (3) step();

    // simultaneous push and pop while holding one entry
    out_ready = 1'b0;
    push(6'h11, DW'(32'h10));
    out_ready = 1'b1;
    push(6'h12, DW'(32'h11));
    out_ready = 1'b0;
    step();
    chk_eq("sim_data", bus.out_data_o, DW'(32'h11));
    out_ready = 1'b1;
    step();

    // reset beats flush and a concurrent push
    out_ready = 1'b0;
    push(6'h21, DW'(32'h20));
    push(6'h22, DW'(32'h21));
    rst   = 1'b1;
    flush = 1'b1;
    push(6'h23, DW'(32'h22));
    rst   = 1'b0;
    flush = 1'b0;
    chk_eq("rp_raw_ctrl", bus0.out_ctrl_o, {CW{1'b0}});
    chk_eq("rp_data", bus.out_data_o, {DW{1'b0}});
    out_ready = 1'b1;
    repeat (3) step();

    // random traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      rnd       = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      in_ctrl   = rnd[127:128-CW];
      in_data   = rnd[DW-1:0];
      step();
    end
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
